pin_console: RTL

Synthesizable successor to the simulation-only pin-output console. It monitors the CPU's `pin_out` bus and `pc`, and captures character strobes into a parametrised FIFO. The captured characters are serialised on a UART-style `tx` line. The block also latches the halt and runaway-PC conditions as sticky status, so the same program image can be run on hardware as well as in simulation.

---
 rtl/pin_console.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pin_console.sv
// pin_console
// -----------------------------------------------------------------------------
// Hardware console for the CPU pin-output bus. Character strobes on pin_out are
// captured into a FIFO and serialised on a UART-style tx line. The block also
// latches the halt request and the runaway-PC condition as sticky status bits.
//
// Optional feature: define PIN_CONSOLE_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. Left undefined, frames are 8N1-like.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   pin_out    : CPU output pins (strobe, halt request, character field)
//   pc         : CPU program counter, compared unsigned against PC_LIMIT
//   tx         : serial output, idle high
//   halted     : sticky, halt request seen
//   fault      : sticky, runaway PC seen
//   overflow   : sticky, a character was dropped on a full FIFO
//   done       : stop latched, FIFO empty and transmitter idle (registered)
//   char_count : characters accepted into the FIFO, saturating
// -----------------------------------------------------------------------------
module pin_console #(
    parameter int WORD_W       = 32,
    parameter int DATA_W       = 8,
    parameter int DATA_LSB     = 2,
    parameter int STB_BIT      = 0,
    parameter int HALT_BIT     = 1,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int PC_LIMIT     = 50,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pin_out,
    input  logic [WORD_W-1:0] pc,
    output logic              tx,
    output logic              halted,
    output logic              fault,
    output logic              overflow,
    output logic              done,
    output logic [CNT_W-1:0]  char_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_W - 1);
    localparam logic [WORD_W-1:0] PC_MAX   = WORD_W'(PC_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef PIN_CONSOLE_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Input decode
    logic              stb_s, halt_req_s, runaway_s, stop_s;
    logic [DATA_W-1:0] char_s;
    logic              unused_pins_s;

    assign stb_s         = pin_out[STB_BIT];
    assign halt_req_s    = pin_out[HALT_BIT];
    assign char_s        = pin_out[DATA_LSB +: DATA_W];
    assign runaway_s     = (pc > PC_MAX);
    assign unused_pins_s = ^pin_out;

    // Registers
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              halted_q, halted_d, fault_q, fault_d;
    logic              overflow_q, overflow_d, done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
`ifdef PIN_CONSOLE_PARITY_EN
    logic              par_q, par_d;
`endif

    logic empty_s, full_s, pop_s, accept_s, push_s, drop_s;

    assign stop_s   = halted_q | fault_q | halt_req_s | runaway_s;
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign accept_s = stb_s & ~stop_s;
    // A full FIFO still takes the character if the transmitter frees a slot this cycle
    assign push_s   = accept_s & (~full_s | pop_s);
    assign drop_s   = accept_s & full_s & ~pop_s;

    // Transmitter next-state, pop request and tx value for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
`ifdef PIN_CONSOLE_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
`ifdef PIN_CONSOLE_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q[AW-1:0]];
`endif
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef PIN_CONSOLE_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1'b1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PIN_CONSOLE_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next frame with no idle gap
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q[AW-1:0]];
`ifdef PIN_CONSOLE_PARITY_EN
                        par_d   = ^mem_q[rd_ptr_q[AW-1:0]];
`endif
                        bit_d   = '0;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers and sticky status next-state
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end
        halted_d   = halted_q | halt_req_s;
        fault_d    = fault_q | runaway_s;
        overflow_d = overflow_q | drop_s;
        done_d     = (halted_q | fault_q) & empty_s & (state_q == ST_IDLE);
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
`ifdef PIN_CONSOLE_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            count_q    <= count_d;
`ifdef PIN_CONSOLE_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= char_s;
        end
    end

    assign tx         = tx_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign overflow   = overflow_q;
    assign done       = done_q;
    assign char_count = count_q;

endmodule
